// File: rtl/stream_xbar_arbiter.sv
// -----------------------------------------------------------------------------
// stream_xbar_arbiter
//
// Per-master-port round-robin arbiter for the AXI-Stream crossbar. It sits
// directly downstream of conflict_finder. Each master port runs a small
// IDLE/LOCKED FSM. In IDLE it picks one requesting slave port. In LOCKED it
// holds that grant for the whole packet, up to and including the TLAST
// handshake. The registered grants drive the slave-side TREADY, the
// master-side TVALID and the datapath mux selects.
//
// Optional feature macro: STREAM_XBAR_ARB_STATS_EN
//   When defined, the block adds one saturating counter per master. The
//   counter records how many arbitrations started while conflict_i was set.
//   The counters appear on the conflict_cnt_o port.
//
// Parameters:
//   S_DATA_COUNT  number of slave (input) ports
//   M_DATA_COUNT  number of master (output) ports
//   CNT_WIDTH     statistics counter width (stats build only)
//
// Ports:
//   clk             clock
//   rst_n           asynchronous active-low reset
//   s_valid_i       TVALID per slave port
//   s_dest_i        TDEST per slave port
//   s_last_i        TLAST per slave port
//   conflict_i      per-master conflict flag from conflict_finder
//   m_ready_i       TREADY per master port
//   s_ready_o       TREADY back to each slave port
//   grant_o         one-hot grant per master, all-zero when idle
//   m_sel_o         index of the granted slave, used as the mux select
//   m_valid_o       TVALID towards each master port
//   conflict_cnt_o  per-master conflict arbitration count (stats build only)
// -----------------------------------------------------------------------------
module stream_xbar_arbiter #(
    parameter int S_DATA_COUNT = 2,
    parameter int M_DATA_COUNT = 3,
`ifdef STREAM_XBAR_ARB_STATS_EN
    parameter int CNT_WIDTH    = 16,
`endif
    localparam int T_DEST_WIDTH = (M_DATA_COUNT > 1) ? $clog2(M_DATA_COUNT) : 1,
    localparam int S_SEL_WIDTH  = (S_DATA_COUNT > 1) ? $clog2(S_DATA_COUNT) : 1
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic [S_DATA_COUNT-1:0]                     s_valid_i,
    input  logic [S_DATA_COUNT-1:0][T_DEST_WIDTH-1:0]   s_dest_i,
    input  logic [S_DATA_COUNT-1:0]                     s_last_i,
    input  logic [M_DATA_COUNT-1:0]                     conflict_i,
    input  logic [M_DATA_COUNT-1:0]                     m_ready_i,
    output logic [S_DATA_COUNT-1:0]                     s_ready_o,
    output logic [M_DATA_COUNT-1:0][S_DATA_COUNT-1:0]   grant_o,
    output logic [M_DATA_COUNT-1:0][S_SEL_WIDTH-1:0]    m_sel_o,
    output logic [M_DATA_COUNT-1:0]                     m_valid_o
`ifdef STREAM_XBAR_ARB_STATS_EN
    ,
    output logic [M_DATA_COUNT-1:0][CNT_WIDTH-1:0]      conflict_cnt_o
`endif
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    arb_state_e                                 state_q [M_DATA_COUNT];
    arb_state_e                                 state_d [M_DATA_COUNT];
    logic [M_DATA_COUNT-1:0][S_DATA_COUNT-1:0]  grant_q;
    logic [M_DATA_COUNT-1:0][S_DATA_COUNT-1:0]  grant_d;
    logic [M_DATA_COUNT-1:0][S_SEL_WIDTH-1:0]   ptr_q;
    logic [M_DATA_COUNT-1:0][S_SEL_WIDTH-1:0]   ptr_d;
    logic [M_DATA_COUNT-1:0][S_DATA_COUNT-1:0]  req;
    logic [S_DATA_COUNT-1:0]                    slave_busy;

    // With a lone requester and no flagged conflict, the requester is taken
    // directly. Otherwise the scan starts at the pointer and wraps. The two
    // paths agree whenever exactly one bit is set. A stale conflict flag
    // therefore never changes the outcome; the local request vector decides.
    function automatic logic [S_DATA_COUNT-1:0] rr_pick(
        input logic [S_DATA_COUNT-1:0] r,
        input logic [S_SEL_WIDTH-1:0]  ptr,
        input logic                    conflict
    );
        logic [S_DATA_COUNT-1:0] pick;
        logic                    found;
        int                      idx;
        pick  = '0;
        found = 1'b0;
        if (!conflict && ($countones(r) == 1)) begin
            pick = r;
        end else begin
            for (int k = 0; k < S_DATA_COUNT; k++) begin
                idx = int'(ptr) + k;
                if (idx >= S_DATA_COUNT) begin
                    idx = idx - S_DATA_COUNT;
                end
                if (!found && r[idx]) begin
                    pick[idx] = 1'b1;
                    found     = 1'b1;
                end
            end
        end
        return pick;
    endfunction

    // Returns the slave index after the granted one, modulo S_DATA_COUNT.
    function automatic logic [S_SEL_WIDTH-1:0] next_ptr(
        input logic [S_DATA_COUNT-1:0] g
    );
        int nxt;
        nxt = 0;
        for (int s = 0; s < S_DATA_COUNT; s++) begin
            if (g[s]) begin
                nxt = (s + 1 == S_DATA_COUNT) ? 0 : s + 1;
            end
        end
        return S_SEL_WIDTH'(nxt);
    endfunction

    // A slave that any master has locked cannot request anywhere else.
    // A master in IDLE holds no grant, so OR-ing every master's grant gives
    // the "locked elsewhere" view for that master. Release happens at a clock
    // edge, so the released slave can request again from the next cycle.
    always_comb begin
        slave_busy = '0;
        for (int m = 0; m < M_DATA_COUNT; m++) begin
            slave_busy = slave_busy | grant_q[m];
        end
    end

    // A destination that is out of range matches no master. Such a slave
    // never requests, so it stays stalled.
    always_comb begin
        req = '0;
        for (int m = 0; m < M_DATA_COUNT; m++) begin
            for (int s = 0; s < S_DATA_COUNT; s++) begin
                req[m][s] = s_valid_i[s]
                          & (s_dest_i[s] == T_DEST_WIDTH'(m))
                          & ~slave_busy[s];
            end
        end
    end

    // Per-master next-state logic. In LOCKED, only the TLAST handshake of
    // the granted slave matters. Changes to dest and drops in valid are
    // ignored until then.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        for (int m = 0; m < M_DATA_COUNT; m++) begin
            case (state_q[m])
                IDLE: begin
                    if (|req[m]) begin
                        grant_d[m] = rr_pick(req[m], ptr_q[m], conflict_i[m]);
                        state_d[m] = LOCKED;
                    end
                end
                LOCKED: begin
                    if ((|(grant_q[m] & s_valid_i & s_last_i)) && m_ready_i[m]) begin
                        grant_d[m] = '0;
                        ptr_d[m]   = next_ptr(grant_q[m]);
                        state_d[m] = IDLE;
                    end
                end
                default: begin
                    grant_d[m] = '0;
                    state_d[m] = IDLE;
                end
            endcase
        end
    end

    // State, grant and pointer registers. Reset abandons any packet in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int m = 0; m < M_DATA_COUNT; m++) begin
                state_q[m] <= IDLE;
            end
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    // Datapath handshake signals come combinationally from the registered
    // grant, so TREADY and TVALID follow the live inputs within a beat.
    always_comb begin
        s_ready_o = '0;
        m_valid_o = '0;
        for (int m = 0; m < M_DATA_COUNT; m++) begin
            m_valid_o[m] = |(grant_q[m] & s_valid_i);
            s_ready_o    = s_ready_o | (grant_q[m] & {S_DATA_COUNT{m_ready_i[m]}});
        end
    end

    // One-hot to binary conversion for the mux select. An idle master
    // selects slave 0.
    always_comb begin
        m_sel_o = '0;
        for (int m = 0; m < M_DATA_COUNT; m++) begin
            for (int s = 0; s < S_DATA_COUNT; s++) begin
                if (grant_q[m][s]) begin
                    m_sel_o[m] = S_SEL_WIDTH'(s);
                end
            end
        end
    end

    assign grant_o = grant_q;

`ifdef STREAM_XBAR_ARB_STATS_EN
    logic [M_DATA_COUNT-1:0][CNT_WIDTH-1:0] conflict_cnt_q;
    logic [M_DATA_COUNT-1:0][CNT_WIDTH-1:0] conflict_cnt_d;

    // An arbitration counts when the master leaves IDLE while its conflict
    // flag is set. The counter saturates at all-ones.
    always_comb begin
        conflict_cnt_d = conflict_cnt_q;
        for (int m = 0; m < M_DATA_COUNT; m++) begin
            if ((state_q[m] == IDLE) && (|req[m]) && conflict_i[m]
                && (conflict_cnt_q[m] != {CNT_WIDTH{1'b1}})) begin
                conflict_cnt_d[m] = conflict_cnt_q[m] + CNT_WIDTH'(1);
            end
        end
    end

    // Statistics counter registers, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt_q <= '0;
        end else begin
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign conflict_cnt_o = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_stream_xbar_arbiter.sv
// -----------------------------------------------------------------------------
// tb_stream_xbar_arbiter
//
// Self-checking bench for stream_xbar_arbiter with S=2 slaves and M=3 masters.
// The bench runs in four parts:
//   1. A table of directed vectors with hand-derived expectations.
//   2. Hand-written multi-cycle sequences: a stalled lock with a dest change,
//      and an asynchronous reset in the middle of a packet.
//   3. Conflict counters, only when STREAM_XBAR_ARB_STATS_EN is defined.
//   4. A randomized run compared against a packet-level reference model.
//      The model tracks who owns each master and the round-robin pointers.
// Inputs change on the falling edge and outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_stream_xbar_arbiter;

    localparam int S    = 2;
    localparam int M    = 3;
    localparam int TDW  = 2;
    localparam int SSW  = 1;
`ifdef STREAM_XBAR_ARB_STATS_EN
    localparam int CNTW = 16;
`endif
    localparam int CNT_MAX = 65535;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [S-1:0]             s_valid_i;
    logic [S-1:0][TDW-1:0]    s_dest_i;
    logic [S-1:0]             s_last_i;
    logic [M-1:0]             conflict_i;
    logic [M-1:0]             m_ready_i;
    logic [S-1:0]             s_ready_o;
    logic [M-1:0][S-1:0]      grant_o;
    logic [M-1:0][SSW-1:0]    m_sel_o;
    logic [M-1:0]             m_valid_o;
`ifdef STREAM_XBAR_ARB_STATS_EN
    logic [M-1:0][CNTW-1:0]   conflict_cnt_o;
`endif

    int checks   = 0;
    int failures = 0;
    bit pending  = 1'b0;

    // Reference model state. An owner of -1 means the master is idle.
    int owner_m [M];
    int ptr_m   [M];
    int cnt_m   [M];

    typedef struct packed {
        logic [1:0] valid;
        logic [3:0] dest;
        logic [1:0] last;
        logic [2:0] conf;
        logic [2:0] rdy;
        logic [5:0] e_grant;
        logic [1:0] e_ready;
        logic [2:0] e_valid;
    } vec_t;

    stream_xbar_arbiter #(
        .S_DATA_COUNT (S),
        .M_DATA_COUNT (M)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid_i  (s_valid_i),
        .s_dest_i   (s_dest_i),
        .s_last_i   (s_last_i),
        .conflict_i (conflict_i),
        .m_ready_i  (m_ready_i),
        .s_ready_o  (s_ready_o),
        .grant_o    (grant_o),
        .m_sel_o    (m_sel_o),
        .m_valid_o  (m_valid_o)
`ifdef STREAM_XBAR_ARB_STATS_EN
        ,
        .conflict_cnt_o (conflict_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    // Watchdog so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic [1:0] v, input logic [3:0] d,
                                input logic [1:0] l, input logic [2:0] c,
                                input logic [2:0] r, input logic [5:0] eg,
                                input logic [1:0] er, input logic [2:0] ev);
        vec_t t;
        t.valid = v; t.dest = d; t.last = l; t.conf = c; t.rdy = r;
        t.e_grant = eg; t.e_ready = er; t.e_valid = ev;
        return t;
    endfunction

    task automatic checkBits(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input logic [5:0] eg,
                               input logic [1:0] er, input logic [2:0] ev);
        checkBits({name, ".grant"},  32'(grant_o),   32'(eg));
        checkBits({name, ".sready"}, 32'(s_ready_o), 32'(er));
        checkBits({name, ".mvalid"}, 32'(m_valid_o), 32'(ev));
    endtask

    task automatic modelReset();
        for (int m = 0; m < M; m++) begin
            owner_m[m] = -1;
            ptr_m[m]   = 0;
            cnt_m[m]   = 0;
        end
    endtask

    // Advance the packet-level model over one rising edge. It uses the
    // inputs that were held across that edge.
    task automatic modelStep();
        int nxt_owner [M];
        int nxt_ptr   [M];
        bit busy      [S];
        for (int s = 0; s < S; s++) busy[s] = 1'b0;
        for (int m = 0; m < M; m++) if (owner_m[m] >= 0) busy[owner_m[m]] = 1'b1;
        for (int m = 0; m < M; m++) begin
            nxt_owner[m] = owner_m[m];
            nxt_ptr[m]   = ptr_m[m];
            if (owner_m[m] < 0) begin
                int cand;
                cand = -1;
                for (int k = 0; k < S; k++) begin
                    int j;
                    j = (ptr_m[m] + k) % S;
                    if (cand < 0 && s_valid_i[j] && int'(s_dest_i[j]) == m && !busy[j])
                        cand = j;
                end
                if (cand >= 0) begin
                    nxt_owner[m] = cand;
                    if (conflict_i[m] && cnt_m[m] < CNT_MAX) cnt_m[m]++;
                end
            end else if (s_valid_i[owner_m[m]] && m_ready_i[m] && s_last_i[owner_m[m]]) begin
                nxt_owner[m] = -1;
                nxt_ptr[m]   = (owner_m[m] + 1) % S;
            end
        end
        owner_m = nxt_owner;
        ptr_m   = nxt_ptr;
    endtask

    task automatic checkModel(input string tag);
        logic [5:0] eg;
        logic [2:0] es;
        logic [1:0] er;
        logic [2:0] ev;
        eg = '0; es = '0; er = '0; ev = '0;
        for (int m = 0; m < M; m++) begin
            if (owner_m[m] >= 0) begin
                eg[m*S + owner_m[m]] = 1'b1;
                es[m] = (owner_m[m] == 1);
                if (s_valid_i[owner_m[m]]) ev[m] = 1'b1;
                if (m_ready_i[m]) er[owner_m[m]] = 1'b1;
            end
        end
        checkBits({tag, ".grant"},  32'(grant_o),   32'(eg));
        checkBits({tag, ".sel"},    32'(m_sel_o),   32'(es));
        checkBits({tag, ".sready"}, 32'(s_ready_o), 32'(er));
        checkBits({tag, ".mvalid"}, 32'(m_valid_o), 32'(ev));
`ifdef STREAM_XBAR_ARB_STATS_EN
        for (int m = 0; m < M; m++)
            checkBits($sformatf("%s.cnt%0d", tag, m), 32'(conflict_cnt_o[m]), 32'(cnt_m[m]));
`endif
    endtask

    // Drive one cycle's inputs on the falling edge. Before that, bring the
    // model up to date with the rising edge that has just passed.
    task automatic applyStimulus(input logic [1:0] v, input logic [3:0] d,
                                 input logic [1:0] l, input logic [2:0] c,
                                 input logic [2:0] r);
        if (pending) modelStep();
        @(negedge clk);
        s_valid_i  = v;
        s_dest_i   = d;
        s_last_i   = l;
        conflict_i = c;
        m_ready_i  = r;
        pending    = 1'b1;
        #1;
    endtask

    task automatic doReset();
        rst_n      = 1'b0;
        s_valid_i  = '0;
        s_dest_i   = '0;
        s_last_i   = '0;
        conflict_i = '0;
        m_ready_i  = '0;
        modelReset();
        pending = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t vecs [19];

    initial begin
        vecs[0]  = mk(2'b11, {2'd1,2'd0}, 2'b11, 3'b000, 3'b111, 6'b000000, 2'b00, 3'b000);
        vecs[1]  = mk(2'b11, {2'd1,2'd0}, 2'b11, 3'b000, 3'b111, 6'b001001, 2'b11, 3'b011);
        vecs[2]  = mk(2'b11, {2'd1,2'd0}, 2'b11, 3'b000, 3'b111, 6'b000000, 2'b00, 3'b000);
        vecs[3]  = mk(2'b11, {2'd1,2'd0}, 2'b11, 3'b000, 3'b111, 6'b001001, 2'b11, 3'b011);
        vecs[4]  = mk(2'b00, {2'd1,2'd0}, 2'b11, 3'b000, 3'b111, 6'b000000, 2'b00, 3'b000);
        vecs[5]  = mk(2'b00, {2'd1,2'd0}, 2'b11, 3'b000, 3'b111, 6'b000000, 2'b00, 3'b000);
        vecs[6]  = mk(2'b11, {2'd1,2'd1}, 2'b00, 3'b010, 3'b111, 6'b000000, 2'b00, 3'b000);
        vecs[7]  = mk(2'b11, {2'd1,2'd1}, 2'b00, 3'b010, 3'b111, 6'b000100, 2'b01, 3'b010);
        vecs[8]  = mk(2'b11, {2'd1,2'd1}, 2'b00, 3'b010, 3'b111, 6'b000100, 2'b01, 3'b010);
        vecs[9]  = mk(2'b11, {2'd1,2'd1}, 2'b11, 3'b010, 3'b111, 6'b000100, 2'b01, 3'b010);
        vecs[10] = mk(2'b11, {2'd1,2'd1}, 2'b00, 3'b010, 3'b111, 6'b000000, 2'b00, 3'b000);
        vecs[11] = mk(2'b11, {2'd1,2'd1}, 2'b00, 3'b010, 3'b111, 6'b001000, 2'b10, 3'b010);
        vecs[12] = mk(2'b11, {2'd1,2'd1}, 2'b00, 3'b010, 3'b111, 6'b001000, 2'b10, 3'b010);
        vecs[13] = mk(2'b11, {2'd1,2'd1}, 2'b11, 3'b010, 3'b111, 6'b001000, 2'b10, 3'b010);
        vecs[14] = mk(2'b00, {2'd1,2'd1}, 2'b00, 3'b010, 3'b111, 6'b000000, 2'b00, 3'b000);
        vecs[15] = mk(2'b11, {2'd1,2'd1}, 2'b00, 3'b010, 3'b111, 6'b000000, 2'b00, 3'b000);
        vecs[16] = mk(2'b11, {2'd1,2'd1}, 2'b00, 3'b010, 3'b101, 6'b000100, 2'b00, 3'b010);
        vecs[17] = mk(2'b11, {2'd3,2'd1}, 2'b00, 3'b000, 3'b111, 6'b000100, 2'b01, 3'b010);
        vecs[18] = mk(2'b11, {2'd3,2'd1}, 2'b00, 3'b000, 3'b111, 6'b000100, 2'b01, 3'b010);

        doReset();
        checkOutput("reset", 6'b0, 2'b0, 3'b0);
        checkBits("reset.sel", 32'(m_sel_o), 32'h0);

        // Directed table
        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].dest, vecs[i].last,
                          vecs[i].conf, vecs[i].rdy);
            checkOutput($sformatf("vec%0d", i), vecs[i].e_grant,
                        vecs[i].e_ready, vecs[i].e_valid);
        end

        // Slave0 locked to master2 while master2 stalls; the dest moves to 0
        // mid-packet.
        doReset();
        applyStimulus(2'b01, {2'd0,2'd2}, 2'b00, 3'b000, 3'b011);
        checkOutput("stall_req", 6'b000000, 2'b00, 3'b000);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(2'b01, {2'd0, (i >= 2) ? 2'd0 : 2'd2},
                          (i == 4) ? 2'b01 : 2'b00, 3'b000, 3'b011);
            checkOutput($sformatf("stall%0d", i), 6'b010000, 2'b00, 3'b100);
        end
        applyStimulus(2'b01, {2'd0,2'd0}, 2'b01, 3'b000, 3'b111);
        checkOutput("stall_hs", 6'b010000, 2'b01, 3'b100);
        applyStimulus(2'b01, {2'd0,2'd0}, 2'b01, 3'b000, 3'b111);
        checkOutput("stall_gap", 6'b000000, 2'b00, 3'b000);
        applyStimulus(2'b01, {2'd0,2'd0}, 2'b01, 3'b000, 3'b111);
        checkOutput("stall_regrant", 6'b000001, 2'b01, 3'b001);

        // Reset mid-packet after master1's pointer has moved to 1.
        doReset();
        applyStimulus(2'b01, {2'd0,2'd1}, 2'b01, 3'b000, 3'b111);
        checkOutput("rst_a", 6'b000000, 2'b00, 3'b000);
        applyStimulus(2'b01, {2'd0,2'd1}, 2'b01, 3'b000, 3'b111);
        checkOutput("rst_b", 6'b000100, 2'b01, 3'b010);
        applyStimulus(2'b01, {2'd0,2'd2}, 2'b00, 3'b000, 3'b111);
        checkOutput("rst_c", 6'b000000, 2'b00, 3'b000);
        applyStimulus(2'b01, {2'd0,2'd2}, 2'b00, 3'b000, 3'b111);
        checkOutput("rst_d", 6'b010000, 2'b01, 3'b100);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst", 6'b000000, 2'b00, 3'b000);
        checkBits("async_rst.sel", 32'(m_sel_o), 32'h0);
        doReset();
        applyStimulus(2'b11, {2'd1,2'd1}, 2'b00, 3'b010, 3'b111);
        checkOutput("rst_e", 6'b000000, 2'b00, 3'b000);
        applyStimulus(2'b11, {2'd1,2'd1}, 2'b00, 3'b010, 3'b111);
        checkOutput("rst_ptr0", 6'b000100, 2'b01, 3'b010);

`ifdef STREAM_XBAR_ARB_STATS_EN
        // Four conflicting arbitrations on master1.
        doReset();
        for (int i = 0; i < 8; i++)
            applyStimulus(2'b11, {2'd1,2'd1}, 2'b11, 3'b010, 3'b111);
        applyStimulus(2'b00, {2'd1,2'd1}, 2'b00, 3'b000, 3'b111);
        checkBits("stats.cnt0", 32'(conflict_cnt_o[0]), 32'd0);
        checkBits("stats.cnt1", 32'(conflict_cnt_o[1]), 32'd4);
        checkBits("stats.cnt2", 32'(conflict_cnt_o[2]), 32'd0);
`endif

        // Randomized traffic against the reference model. Dest 3 is out of
        // range, and the conflict flags are random, so some of them are stale.
        doReset();
        for (int i = 0; i < 400; i++) begin
            logic [1:0] v, l;
            logic [3:0] d;
            logic [2:0] c, r;
            v = 2'($urandom_range(0, 3));
            d = 4'($urandom_range(0, 15));
            l = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
            c = 3'($urandom_range(0, 7));
            r = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 3) != 0)};
            applyStimulus(v, d, l, c, r);
            checkModel($sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stream_xbar_arbiter.md
Name: stream_xbar_arbiter

Overview:
- Per-master-port round-robin arbiter for the AXI-Stream crossbar, directly downstream of conflict_finder.
- Takes each slave port's destination and valid, plus conflict_finder's per-master conflict flags, and issues one packet-locked grant per master port.
- Grant is held from first beat to the TLAST handshake; s_ready and mux select are driven back to the datapath.

Parameters:
S_DATA_COUNT, 2, number of slave (input) ports
M_DATA_COUNT, 3, number of master (output) ports
T_DEST_WIDTH, $clog2(M_DATA_COUNT), width of each s_dest_i element (localparam)
S_SEL_WIDTH, $clog2(S_DATA_COUNT) min 1, width of each m_sel_o element (localparam)
CNT_WIDTH, 16, width of statistics counters (optional feature only)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
s_valid_i  in  [S_DATA_COUNT]  TVALID per slave port
s_dest_i  in  [S_DATA_COUNT][T_DEST_WIDTH]  TDEST per slave port
s_last_i  in  [S_DATA_COUNT]  TLAST per slave port
conflict_i  in  [M_DATA_COUNT]  from conflict_finder, 1 = two or more slaves target master m
m_ready_i  in  [M_DATA_COUNT]  TREADY per master port
s_ready_o  out  [S_DATA_COUNT]  TREADY back to each slave port
grant_o  out  [M_DATA_COUNT][S_DATA_COUNT]  one-hot grant per master, 0 = idle
m_sel_o  out  [M_DATA_COUNT][S_SEL_WIDTH]  index of granted slave, mux select
m_valid_o  out  [M_DATA_COUNT]  TVALID to master m, equals s_valid_i of granted slave while locked

Behaviour:
- Reset (async, rst_n=0):
  - all grant_o=0, m_sel_o=0, m_valid_o=0, s_ready_o=0.
  - All FSMs go to IDLE; all RR pointers go to 0.
  - A packet in flight is abandoned; no partial state is kept.
- Request: req[m][s] = s_valid_i[s] & (s_dest_i[s]==m) & ~locked_elsewhere[s].
  - locked_elsewhere[s] = slave s currently granted by any other master.
  - s_dest_i >= M_DATA_COUNT never requests; that slave stalls (s_ready_o=0).
- Per-master FSM, states IDLE and LOCKED:
  - IDLE, no req: stay IDLE, grant 0.
  - IDLE, conflict_i[m]=0 and exactly one req: grant that slave on the next edge; RR pointer unchanged.
  - IDLE, conflict_i[m]=1 (or more than one req): grant the first requester at or after the pointer, wrapping modulo S_DATA_COUNT, on the next edge.
  - If conflict_i[m] disagrees with the local req count, the local req count wins (robust to a stale conflict flag).
  - LOCKED: grant held regardless of s_dest_i changes or s_valid_i dropping.
  - LOCKED: on handshake (s_valid_i[g] & m_ready_i[m] & s_last_i[g]) go to IDLE and set pointer = (g+1) mod S_DATA_COUNT.
- Latency:
  - Grant appears 1 cycle after the request is seen in IDLE.
  - After a TLAST handshake, grant_o drops to 0 for exactly one cycle (IDLE); re-arbitration is then registered, so the next grant has a 1-cycle bubble.
- Outputs, combinational from registered grant:
  - s_ready_o[s] = OR over m of (grant[m][s] & m_ready_i[m]).
  - m_valid_o[m] = OR over s of (grant[m][s] & s_valid_i[s]).
- Invariant: each slave is granted by at most one master; each grant_o[m] is zero or one-hot.
- Simultaneous events:
  - Master m releasing and master n arbitrating in the same cycle are independent.
  - A slave releasing m is not visible as a requester to another master until the following cycle.

Optional Feature:
Macro STREAM_XBAR_ARB_STATS_EN.
- Defined:
  - adds output port conflict_cnt_o [M_DATA_COUNT][CNT_WIDTH].
  - Increments when master m leaves IDLE with conflict_i[m]=1.
  - Saturates at all-ones; cleared by reset.
- Not defined: port and counters absent; behaviour otherwise identical.

Test Plan:
- S=2,M=3; dest0=0, dest1=1, both valid, single-beat last -> grant_o[0]=01, grant_o[1]=10 one cycle later; both s_ready_o=1 with m_ready=1.
- dest0=dest1=1, conflict_i=010, pointer 0, 3-beat packets -> slave0 granted 3 beats, 1 idle cycle, then slave1 granted 3 beats; pointer ends at 0.
- Slave0 locked to master2, m_ready_i[2] held 0 for 5 cycles -> grant held, s_ready_o[0]=0, no other grant to slave0; release on first last handshake after m_ready rises.
- s_dest_i[0] changed 2→0 mid-packet while locked to master2 -> grant_o[2] stays 01, grant_o[0] stays 0 until the TLAST handshake.
- Assert rst_n=0 mid-packet -> all outputs 0 asynchronously; after release, a fresh request is granted from pointer 0.
- With STREAM_XBAR_ARB_STATS_EN, 4 conflicting arbitrations on master1 -> conflict_cnt_o[1]=4, others 0.
